// File: rtl/mux2_arbiter_if.sv
// Request/grant bundle between two requesters and the arbiter that owns the 2:1 mux select.
// The master side is the requester pair; the slave side is the arbiter.
interface mux2_arbiter_if;
  logic req0;
  logic req1;
  logic grant0;
  logic grant1;
  logic sel;
  logic busy;

  modport master (
    output req0,
    output req1,
    input  grant0,
    input  grant1,
    input  sel,
    input  busy
  );

  modport slave (
    input  req0,
    input  req1,
    output grant0,
    output grant1,
    output sel,
    output busy
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Two-way round-robin arbiter with a hold limit; drives the select of a shared 2:1 datapath mux.
// Ownership is released only by dropping the request or by preemption after MAX_HOLD cycles.
module mux2_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mux2_arbiter_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StOwn0 = 2'b01;
  localparam logic [1:0] StOwn1 = 2'b10;

  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sel_q, sel_d;

  logic             cur;
  logic             own_req;
  logic             oth_req;
  logic             enter;
  logic             new_owner;

  // Current owner's and the other side's requests, seen from whichever side owns.
  assign cur     = (state_q == StOwn1);
  assign own_req = cur ? bus.req1 : bus.req0;
  assign oth_req = cur ? bus.req0 : bus.req1;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    count_d   = count_q;
    sel_d     = sel_q;
    enter     = 1'b0;
    new_owner = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.req0 && bus.req1) begin
          enter     = 1'b1;
          new_owner = ~last_q;
        end else if (bus.req0) begin
          enter     = 1'b1;
          new_owner = 1'b0;
        end else if (bus.req1) begin
          enter     = 1'b1;
          new_owner = 1'b1;
        end
      end

      StOwn0, StOwn1: begin
        if (!own_req) begin
          if (oth_req) begin
            enter     = 1'b1;
            new_owner = ~cur;
          end else begin
            state_d = StIdle;
          end
        end else if (oth_req && (count_q == HoldMax)) begin
          enter     = 1'b1;
          new_owner = ~cur;
        end else if (count_q != HoldMax) begin
          count_d = count_q + CNT_W'(1);
        end
      end

      default: state_d = StIdle;
    endcase

    // Every entry into ownership restarts the hold window and records the owner for round-robin.
    if (enter) begin
      state_d = new_owner ? StOwn1 : StOwn0;
      count_d = '0;
      last_d  = new_owner;
      sel_d   = new_owner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      count_q <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      count_q <= count_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.grant0 = (state_q == StOwn0);
  assign bus.grant1 = (state_q == StOwn1);
  assign bus.busy   = (state_q == StOwn0) || (state_q == StOwn1);
  assign bus.sel    = sel_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: MAX_HOLD=8 and MAX_HOLD=1 instances share one request stream.
// A driver pushes model predictions per cycle; a monitor pops and compares after each rising edge.
module tb_mux2_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic req0 = 1'b0;
  logic req1 = 1'b0;

  mux2_arbiter_if if8 ();
  mux2_arbiter_if if1 ();

  assign if8.req0 = req0;
  assign if8.req1 = req1;
  assign if1.req0 = req0;
  assign if1.req1 = req1;

  mux2_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  mux2_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [3:0] q8[$];
  logic [3:0] q1[$];

  // Reference model: owner (-1 idle), cycles owned so far, last winner, select.
  int m_owner[2];
  int m_run[2];
  int m_last[2];
  bit m_sel[2];
  int m_hold[2] = '{8, 1};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1;
      m_run[i]   = 0;
      m_last[i]  = 1;
      m_sel[i]   = 1'b0;
    end
  endfunction

  function automatic void take(int i, int x);
    m_owner[i] = x;
    m_run[i]   = 1;
    m_last[i]  = x;
    m_sel[i]   = (x == 1);
  endfunction

  // Returns {grant0, grant1, sel, busy} expected after the next rising edge.
  function automatic logic [3:0] model_step(int i, bit r0, bit r1);
    bit r[2];
    int o;
    r[0] = r0;
    r[1] = r1;
    o    = m_owner[i];
    if (o < 0) begin
      if (r0 && r1) take(i, 1 - m_last[i]);
      else if (r0)  take(i, 0);
      else if (r1)  take(i, 1);
    end else if (!r[o]) begin
      if (r[1-o]) take(i, 1 - o);
      else        m_owner[i] = -1;
    end else if (r[1-o] && (m_run[i] >= m_hold[i])) begin
      take(i, 1 - o);
    end else begin
      m_run[i]++;
    end
    return {m_owner[i] == 0, m_owner[i] == 1, m_sel[i], m_owner[i] >= 0};
  endfunction

  function automatic logic [3:0] observe(int i);
    if (i == 0) return {if8.grant0, if8.grant1, if8.sel, if8.busy};
    return {if1.grant0, if1.grant1, if1.sel, if1.busy};
  endfunction

  task automatic cycle(bit r0, bit r1);
    @(negedge clk);
    req0 = r0;
    req1 = r1;
    q8.push_back(model_step(0, r0, r1));
    q1.push_back(model_step(1, r0, r1));
    mon_en = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (q8.size() == 0 || q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got empty queue expected prediction at %0t", $time);
        end else begin
          check("sb_hold8", observe(0), q8.pop_front());
          check("sb_hold1", observe(1), q1.pop_front());
        end
      end
    end
  end

  initial begin
    int g0cnt;
    int first_g1;
    bit r0;
    bit r1;

    // Reset held with both requesting, across a clock edge.
    rst_n = 1'b0;
    req0  = 1'b1;
    req1  = 1'b1;
    model_reset();
    #8;
    check("reset_out8", observe(0), 4'b0000);
    check("reset_out1", observe(1), 4'b0000);
    rst_n = 1'b1;

    cycle(1, 1);
    settle();
    check("first_tie8", observe(0), 4'b1001);
    check("first_tie1", observe(1), 4'b1001);
    cycle(0, 0);

    // Single requester 1, then release: Sel stays 1 in idle.
    repeat (5) cycle(0, 1);
    cycle(0, 0);
    settle();
    check("idle_sel_hold", observe(0), 4'b0010);

    // Tie after requester 0 last won goes to requester 1, and then back to 0.
    cycle(1, 0);
    cycle(0, 0);
    cycle(1, 1);
    settle();
    check("tie_rr_to1", observe(0), 4'b0111);
    cycle(0, 0);
    cycle(1, 1);
    settle();
    check("tie_rr_to0", observe(0), 4'b1001);
    cycle(0, 0);

    // Preemption: req0 held, req1 raised in the 4th owned cycle.
    g0cnt    = 0;
    first_g1 = -1;
    for (int k = 0; k < 12; k++) begin
      cycle(1, k >= 3);
      settle();
      if (first_g1 < 0) begin
        if (if8.grant1) first_g1 = k;
        else if (if8.grant0) g0cnt++;
      end
    end
    check("preempt_len", g0cnt, 8);
    check("preempt_turn", first_g1, 8);
    cycle(0, 0);

    // Zero-bubble hand-over.
    cycle(1, 0);
    cycle(1, 1);
    cycle(0, 1);
    settle();
    check("handover", observe(0), 4'b0111);
    cycle(0, 0);

    // Asynchronous reset pulse between edges while requester 1 owns.
    repeat (5) cycle(0, 1);
    settle();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_rst8", observe(0), 4'b0000);
    check("async_rst1", observe(1), 4'b0000);
    rst_n = 1'b1;
    model_reset();
    cycle(1, 1);
    settle();
    check("post_rst_tie", observe(0), 4'b1001);

    // Random request streams with persistence.
    r0 = 1'b1;
    r1 = 1'b1;
    repeat (600) begin
      if ($urandom_range(3) == 0) r0 = ~r0;
      if ($urandom_range(3) == 0) r1 = ~r1;
      cycle(r0, r1);
    end

    cycle(0, 0);
    settle();
    mon_en = 1'b0;
    check("sb_drain", q8.size() + q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
